// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
//   Shared definitions for the LCD serial link. The receiver and the
//   transmitter both use this package, so the word size, the synchronizer
//   depth and the state encoding are the same on both sides.
//
//   Contents:
//     LCD_DATA_WIDTH   default bits per serial word (sent MSB first)
//     LCD_SYNC_STAGES  default synchronizer depth on each serial input
//     lcd_state_e      serial FSM state encoding (IDLE, SHIFT)
//     lcd_cnt_width()  width of a counter that must hold 0..width-1
// ---------------------------------------------------------------------------
package lcd_pkg;

  localparam int LCD_DATA_WIDTH  = 8;
  localparam int LCD_SYNC_STAGES = 2;

  typedef enum logic [0:0] {
    LCD_IDLE  = 1'b0,
    LCD_SHIFT = 1'b1
  } lcd_state_e;

  // Bit-counter width for a word of w bits. The counter only needs to hold
  // 0..w-1, because it clears on the final bit instead of reaching w.
  function automatic int lcd_cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/lcd_sync.sv
// ---------------------------------------------------------------------------
// lcd_sync
//   Flop-chain synchronizer for one asynchronous input bit.
//
//   Parameters:
//     DEPTH      number of flops in the chain (2 or more)
//     RESET_VAL  value loaded into every stage on reset. Set it to the idle
//                level of the line so that reset creates no false edge.
//
//   Ports:
//     clk       system clock
//     rst       synchronous active-high reset
//     async_in  raw input, asynchronous to clk
//     sync_out  synchronized copy, DEPTH clk edges behind async_in
// ---------------------------------------------------------------------------
module lcd_sync #(
  parameter int   DEPTH     = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic [DEPTH-1:0] stage_q;
  logic [DEPTH-1:0] stage_d;

  always_comb begin
    stage_d = {stage_q[DEPTH-2:0], async_in};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= {DEPTH{RESET_VAL}};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign sync_out = stage_q[DEPTH-1];

endmodule

// File: rtl/lcd_spi_receiver.sv
// ---------------------------------------------------------------------------
// lcd_spi_receiver
//   Receiver for the write-only serial bus of an LCD controller. The bus has
//   a chip select (active low), a clock that idles high, data that is sampled
//   on the rising edge of the serial clock, and a register-select line.
//   Every serial input goes through a synchronizer. The serial clock is then
//   edge-detected in the clk domain. A word is shifted in MSB first, and
//   each completed word goes into a holding register. A valid/ready
//   handshake drains that register.
//
//   Parameters:
//     DATA_WIDTH   bits per serial word
//     SYNC_STAGES  synchronizer depth (values below 2 are raised to 2)
//
//   Ports:
//     clk            system clock, all state on rising edge
//     rst            synchronous active-high reset
//     cs_lcd         serial chip select, active low, asynchronous
//     scl_lcd        serial clock, idles high
//     sda_lcd        serial data
//     rs_lcd         register select (0 index, 1 data)
//     data_out       received word
//     index_or_data  rs_lcd value captured with data_out
//     valid_out      holding register contains a word not yet accepted
//     ready_in       consumer accepts when valid_out & ready_in
//     frame_err      one-cycle pulse: chip select released mid-word
//     overrun        one-cycle pulse: word lost because holding register full
// ---------------------------------------------------------------------------
module lcd_spi_receiver
  import lcd_pkg::*;
#(
  parameter int DATA_WIDTH  = LCD_DATA_WIDTH,
  parameter int SYNC_STAGES = LCD_SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs_lcd,
  input  logic                  scl_lcd,
  input  logic                  sda_lcd,
  input  logic                  rs_lcd,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  index_or_data,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int SYNC_DEPTH = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int CW         = lcd_cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  // Bit order in the synchronizer vectors: 0 cs, 1 scl, 2 sda, 3 rs.
  // The reset values are the idle levels of the lines (cs and scl high).
  localparam logic [3:0] SYNC_RST = 4'b0011;

  logic [3:0] raw_in;
  logic [3:0] sync_in;
  logic       cs_s;
  logic       scl_s;
  logic       sda_s;
  logic       rs_s;

  assign raw_in = {rs_lcd, sda_lcd, scl_lcd, cs_lcd};

  for (genvar gi = 0; gi < 4; gi++) begin : g_sync
    lcd_sync #(
      .DEPTH     (SYNC_DEPTH),
      .RESET_VAL (SYNC_RST[gi])
    ) u_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (raw_in[gi]),
      .sync_out (sync_in[gi])
    );
  end

  assign cs_s  = sync_in[0];
  assign scl_s = sync_in[1];
  assign sda_s = sync_in[2];
  assign rs_s  = sync_in[3];

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  lcd_state_e            state_q,     state_d;
  logic [CW-1:0]         cnt_q,       cnt_d;
  logic [DATA_WIDTH-1:0] shift_q,     shift_d;
  logic                  rs_cap_q,    rs_cap_d;
  logic                  scl_prev_q,  scl_prev_d;
  logic [DATA_WIDTH-1:0] data_q,      data_d;
  logic                  index_q,     index_d;
  logic                  valid_q,     valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q,   overrun_d;

  logic                  scl_rise;
  logic                  word_done;
  logic [DATA_WIDTH-1:0] word_val;
  logic                  word_rs;

  // The previous-scl flop resets high. Reset therefore never produces a
  // false rising edge.
  assign scl_rise = scl_s & ~scl_prev_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    rs_cap_d    = rs_cap_q;
    scl_prev_d  = scl_s;
    data_d      = data_q;
    index_d     = index_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    word_done   = 1'b0;

    // Shift-register contents including the bit arriving now. On the
    // final edge this is the whole word. On a one-bit word the rs value
    // has not been captured yet, so take it directly.
    word_val = (shift_q << 1) | DATA_WIDTH'(sda_s);
    word_rs  = (cnt_q == '0) ? rs_s : rs_cap_q;

    unique case (state_q)
      LCD_IDLE: begin
        if (!cs_s) begin
          state_d = LCD_SHIFT;
          cnt_d   = '0;
        end
      end

      LCD_SHIFT: begin
        if (cs_s) begin
          // Chip select released. A partial word is an error and is dropped.
          state_d     = LCD_IDLE;
          frame_err_d = (cnt_q != '0);
          cnt_d       = '0;
          shift_d     = '0;
        end else if (scl_rise) begin
          shift_d = word_val;
          if (cnt_q == '0) begin
            rs_cap_d = rs_s;
          end
          if (cnt_q == LAST_BIT) begin
            // Stay in SHIFT. Several words may share one chip-select frame.
            word_done = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      default: begin
        state_d = LCD_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Holding register. A word that completes on the same edge where the
    // consumer takes the old word replaces it, and valid stays high.
    if (word_done) begin
      if (valid_q && !ready_in) begin
        overrun_d = 1'b1;
      end else begin
        data_d  = word_val;
        index_d = word_rs;
        valid_d = 1'b1;
      end
    end else if (valid_q && ready_in) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LCD_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      rs_cap_q    <= 1'b0;
      scl_prev_q  <= 1'b1;
      data_q      <= '0;
      index_q     <= 1'b0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      rs_cap_q    <= rs_cap_d;
      scl_prev_q  <= scl_prev_d;
      data_q      <= data_d;
      index_q     <= index_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data_out      = data_q;
  assign index_or_data = index_q;
  assign valid_out     = valid_q;
  assign frame_err     = frame_err_q;
  assign overrun       = overrun_q;

endmodule
